uart_tx_sched: RTL and testbench

UART_TX_SCHED -- requirements
Module: uart_tx_sched

---
 rtl/uart_tx_sched.sv | 131 +++++++++++++
 tb/tb_uart_tx_sched.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// Two-requester round-robin scheduler feeding a byte-wide UART transmitter.
// States: IDLE arbitrate, LOAD strobe byte, WAIT_BUSY await tx start, WAIT_DONE await tx end.
module uart_tx_sched #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req0_vld,
    input  logic [DATA_WIDTH-1:0]   req0_data,
    output logic                    req0_ack,
    input  logic                    req1_vld,
    input  logic [2*DATA_WIDTH-1:0] req1_data,
    output logic                    req1_ack,
    input  logic                    tx_busy,
    output logic [DATA_WIDTH-1:0]   tx_p_data,
    output logic                    tx_data_valid,
    output logic                    grant_id,
    output logic                    sched_busy
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t                    state, state_nxt;
    logic                      ptr, ptr_nxt;
    logic                      hi_pending, hi_pending_nxt;
    logic [1:0]                tmo_cnt, tmo_cnt_nxt;
    logic [2*DATA_WIDTH-1:0]   hold, hold_nxt;
    logic [DATA_WIDTH-1:0]     p_data_nxt;
    logic                      grant_nxt;
    logic                      ack0_nxt, ack1_nxt;
    logic                      valid_nxt, sbusy_nxt;
    logic                      winner;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            ptr           <= 1'b0;
            hi_pending    <= 1'b0;
            tmo_cnt       <= 2'd0;
            hold          <= '0;
            tx_p_data     <= '0;
            grant_id      <= 1'b0;
            req0_ack      <= 1'b0;
            req1_ack      <= 1'b0;
            tx_data_valid <= 1'b0;
            sched_busy    <= 1'b0;
        end else begin
            state         <= state_nxt;
            ptr           <= ptr_nxt;
            hi_pending    <= hi_pending_nxt;
            tmo_cnt       <= tmo_cnt_nxt;
            hold          <= hold_nxt;
            tx_p_data     <= p_data_nxt;
            grant_id      <= grant_nxt;
            req0_ack      <= ack0_nxt;
            req1_ack      <= ack1_nxt;
            tx_data_valid <= valid_nxt;
            sched_busy    <= sbusy_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        ptr_nxt        = ptr;
        hi_pending_nxt = hi_pending;
        tmo_cnt_nxt    = tmo_cnt;
        hold_nxt       = hold;
        p_data_nxt     = tx_p_data;
        grant_nxt      = grant_id;
        ack0_nxt       = 1'b0;
        ack1_nxt       = 1'b0;
        winner         = 1'b0;

        case (state)
            IDLE: begin
                if (!tx_busy && (req0_vld || req1_vld)) begin
                    // A lone requester wins outright; a tie goes to the pointer side.
                    winner    = (req0_vld && req1_vld) ? ptr : req1_vld;
                    grant_nxt = winner;
                    ptr_nxt   = ~winner;
                    state_nxt = LOAD;
                    if (winner) begin
                        hold_nxt       = req1_data;
                        p_data_nxt     = req1_data[DATA_WIDTH-1:0];
                        hi_pending_nxt = 1'b1;
                        ack1_nxt       = 1'b1;
                    end else begin
                        hold_nxt       = {{DATA_WIDTH{1'b0}}, req0_data};
                        p_data_nxt     = req0_data;
                        hi_pending_nxt = 1'b0;
                        ack0_nxt       = 1'b1;
                    end
                end
            end
            LOAD: begin
                state_nxt   = WAIT_BUSY;
                tmo_cnt_nxt = 2'd0;
            end
            WAIT_BUSY: begin
                tmo_cnt_nxt = tmo_cnt + 2'd1;
                if (tx_busy) begin
                    state_nxt = WAIT_DONE;
                end else if (tmo_cnt == 2'd3) begin
                    // Transmitter never picked the byte up: strobe it again.
                    state_nxt = LOAD;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    if (hi_pending) begin
                        hi_pending_nxt = 1'b0;
                        p_data_nxt     = hold[2*DATA_WIDTH-1:DATA_WIDTH];
                        state_nxt      = LOAD;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        valid_nxt = (state_nxt == LOAD);
        sbusy_nxt = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: a cycle table for single transfers plus
// sequences for timeout re-issue, round-robin fairness and mid-transfer reset.
module tb_uart_tx_sched;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_vld;
    logic [DW-1:0] req0_data;
    logic          req0_ack;
    logic          req1_vld;
    logic [2*DW-1:0] req1_data;
    logic          req1_ack;
    logic          tx_busy;
    logic [DW-1:0] tx_p_data;
    logic          tx_data_valid;
    logic          grant_id;
    logic          sched_busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    uart_tx_sched #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .req0_vld(req0_vld), .req0_data(req0_data), .req0_ack(req0_ack),
        .req1_vld(req1_vld), .req1_data(req1_data), .req1_ack(req1_ack),
        .tx_busy(tx_busy), .tx_p_data(tx_p_data), .tx_data_valid(tx_data_valid),
        .grant_id(grant_id), .sched_busy(sched_busy)
    );

    typedef struct {
        logic          rst;
        logic          r0v;
        logic [7:0]    r0d;
        logic          r1v;
        logic [15:0]   r1d;
        logic          busy;
        logic          e_ack0;
        logic          e_ack1;
        logic          e_vld;
        logic [7:0]    e_p;
        logic          e_gid;
        logic          e_sb;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [12:0] outs();
        return {req0_ack, req1_ack, tx_data_valid, grant_id, sched_busy, tx_p_data};
    endfunction

    task automatic do_reset();
        rst = 1'b0; req0_vld = 1'b0; req1_vld = 1'b0; tx_busy = 1'b0;
        step();
        rst = 1'b1;
    endtask

    int   pulses, acks, bad_pos, overlaps, ngr, cyc, busy_cnt;
    logic got_gid[4];
    logic got_ok[4];
    logic exp_gid[4];

    initial begin
        rst = 1'b0; req0_vld = 1'b0; req0_data = '0; req1_vld = 1'b0; req1_data = '0; tx_busy = 1'b0;

        //          rst r0v r0d    r1v r1d       busy a0 a1 v  p      g  sb
        vecs[0]  = '{0, 0, 8'h00, 0, 16'h0000, 0,   0, 0, 0, 8'h00, 0, 0};
        vecs[1]  = '{1, 1, 8'hA5, 0, 16'h0000, 0,   1, 0, 1, 8'hA5, 0, 1};
        vecs[2]  = '{1, 0, 8'hA5, 0, 16'h0000, 0,   0, 0, 0, 8'hA5, 0, 1};
        vecs[3]  = '{1, 0, 8'hA5, 0, 16'h0000, 1,   0, 0, 0, 8'hA5, 0, 1};
        vecs[4]  = '{1, 0, 8'hA5, 0, 16'h0000, 1,   0, 0, 0, 8'hA5, 0, 1};
        vecs[5]  = '{1, 0, 8'hA5, 0, 16'h0000, 0,   0, 0, 0, 8'hA5, 0, 0};
        vecs[6]  = '{1, 0, 8'h00, 1, 16'h1234, 0,   0, 1, 1, 8'h34, 1, 1};
        vecs[7]  = '{1, 0, 8'h00, 0, 16'h1234, 0,   0, 0, 0, 8'h34, 1, 1};
        vecs[8]  = '{1, 0, 8'h00, 0, 16'h1234, 1,   0, 0, 0, 8'h34, 1, 1};
        vecs[9]  = '{1, 0, 8'h00, 0, 16'h1234, 1,   0, 0, 0, 8'h34, 1, 1};
        vecs[10] = '{1, 0, 8'h00, 0, 16'h1234, 0,   0, 0, 1, 8'h12, 1, 1};
        vecs[11] = '{1, 0, 8'h00, 0, 16'h1234, 0,   0, 0, 0, 8'h12, 1, 1};
        vecs[12] = '{1, 0, 8'h00, 0, 16'h1234, 1,   0, 0, 0, 8'h12, 1, 1};
        vecs[13] = '{1, 0, 8'h00, 0, 16'h1234, 0,   0, 0, 0, 8'h12, 1, 0};
        vecs[14] = '{1, 1, 8'h5A, 0, 16'h0000, 1,   0, 0, 0, 8'h12, 1, 0};
        vecs[15] = '{1, 1, 8'h5A, 0, 16'h0000, 1,   0, 0, 0, 8'h12, 1, 0};
        vecs[16] = '{1, 1, 8'h5A, 0, 16'h0000, 0,   1, 0, 1, 8'h5A, 0, 1};
        vecs[17] = '{1, 0, 8'h5A, 0, 16'h0000, 0,   0, 0, 0, 8'h5A, 0, 1};
        vecs[18] = '{1, 0, 8'h5A, 0, 16'h0000, 1,   0, 0, 0, 8'h5A, 0, 1};
        vecs[19] = '{1, 0, 8'h5A, 0, 16'h0000, 0,   0, 0, 0, 8'h5A, 0, 0};

        for (int i = 0; i < 20; i++) begin
            rst = vecs[i].rst; req0_vld = vecs[i].r0v; req0_data = vecs[i].r0d;
            req1_vld = vecs[i].r1v; req1_data = vecs[i].r1d; tx_busy = vecs[i].busy;
            step();
            check($sformatf("vec%0d", i), {19'd0, outs()},
                  {19'd0, vecs[i].e_ack0, vecs[i].e_ack1, vecs[i].e_vld,
                   vecs[i].e_gid, vecs[i].e_sb, vecs[i].e_p});
        end

        // Transmitter never goes busy: strobe repeats every 5 cycles, single ACK.
        do_reset();
        req0_vld = 1'b1; req0_data = 8'h3C; tx_busy = 1'b0;
        pulses = 0; acks = 0; bad_pos = 0;
        for (int e = 1; e <= 16; e++) begin
            step();
            if (e == 1) req0_vld = 1'b0;
            if (tx_data_valid) pulses++;
            if (req0_ack || req1_ack) acks++;
            if (tx_data_valid !== ((e % 5) == 1)) bad_pos++;
            if (tx_p_data !== 8'h3C) bad_pos++;
        end
        check("timeout_pulses", pulses, 4);
        check("timeout_acks", acks, 1);
        check("timeout_pattern", bad_pos, 0);

        // Both requesters held: grants alternate starting from requester 0.
        do_reset();
        req0_vld = 1'b1; req0_data = 8'h11; req1_vld = 1'b1; req1_data = 16'hBBAA;
        exp_gid[0] = 1'b0; exp_gid[1] = 1'b1; exp_gid[2] = 1'b0; exp_gid[3] = 1'b1;
        ngr = 0; overlaps = 0; busy_cnt = 0; cyc = 0;
        while (ngr < 4 && cyc < 300) begin
            step();
            cyc++;
            if (req0_ack && req1_ack) overlaps++;
            if (req0_ack || req1_ack) begin
                got_gid[ngr] = req1_ack;
                got_ok[ngr]  = (grant_id === req1_ack) &&
                               (tx_p_data === (req1_ack ? 8'hAA : 8'h11));
                ngr++;
            end
            if (tx_data_valid) busy_cnt = 3;
            tx_busy = (busy_cnt > 0);
            if (busy_cnt > 0) busy_cnt--;
        end
        check("rr_grant_count", ngr, 4);
        for (int k = 0; k < 4; k++) begin
            if (k < ngr) begin
                check($sformatf("rr_grant%0d", k), {31'd0, got_gid[k]}, {31'd0, exp_gid[k]});
                check($sformatf("rr_gid_data%0d", k), {31'd0, got_ok[k]}, 32'd1);
            end
        end
        check("rr_ack_overlap", overlaps, 0);

        // Reset while the low byte of a two-byte word is on the wire.
        do_reset();
        req1_vld = 1'b1; req1_data = 16'h1234; tx_busy = 1'b0;
        step();
        check("rst_mid_grant", {19'd0, outs()}, {19'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h34});
        req1_vld = 1'b0; tx_busy = 1'b1;
        step();
        step();
        step();
        rst = 1'b0;
        step();
        check("rst_mid_outputs", {19'd0, outs()}, 32'd0);
        rst = 1'b1; tx_busy = 1'b0;
        step();
        check("rst_mid_after", {19'd0, outs()}, 32'd0);
        pulses = 0;
        for (int e = 0; e < 8; e++) begin
            step();
            if (tx_data_valid || req0_ack || req1_ack) pulses++;
        end
        check("rst_no_high_byte", pulses, 0);
        req0_vld = 1'b1; req0_data = 8'h77; req1_vld = 1'b1; req1_data = 16'hCCDD;
        step();
        check("rst_ptr_zero", {19'd0, outs()}, {19'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h77});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
